// File: rtl/sdram_test_pkg.sv
// Shared definitions for the SDRAM bring-up test logic (checker and tester).
// Latency: n/a (types, constants and a pure combinational helper).
// Backpressure: n/a.
package sdram_test_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_e;

  // Burst length shared by the tester FSM and the response checker.
  localparam int DEFAULT_BURST_LENGTH = 8;

  // Expected read-back pattern: the word address itself, optionally inverted.
  // Callers truncate the result to their data width, so the low address bits
  // become the data word.
  function automatic logic [63:0] exp_data(input logic [63:0] addr, input logic invert);
    return invert ? ~addr : addr;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: count updates the cycle after inc/clr; clr has priority over inc.
// Backpressure: none; holds at all-ones once saturated.
// Ports: clk, rst (async active-high), clr, inc, count[WIDTH-1:0].
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sdram_resp_checker.sv
// Checks SDRAM read-response beats against an address-derived pattern, checks
//   burst framing, counts mismatches and latches the first failing beat.
// Latency: all status outputs registered, valid the cycle after the causing handshake.
// Backpressure: resp_ready_o high only while running and stall_i low; one beat/cycle.
// Ports: clk_axi/rst_axi; start_i + base_addr_i/num_bursts_i/invert_i config;
//   stall_i test hook; resp_valid_i/resp_last_i/resp_data_i/resp_ready_o beat stream;
//   busy_o/done_o/pass_o/err_count_o/framing_err_o/first_err_addr_o/first_err_data_o status.
module sdram_resp_checker
  import sdram_test_pkg::*;
#(
  parameter int ADDR_WIDTH    = 24,
  parameter int DATA_WIDTH    = 16,
  parameter int BURST_LENGTH  = DEFAULT_BURST_LENGTH,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk_axi,
  input  logic                     rst_axi,
  input  logic                     start_i,
  input  logic [ADDR_WIDTH-1:0]    base_addr_i,
  input  logic [15:0]              num_bursts_i,
  input  logic                     invert_i,
  input  logic                     stall_i,
  input  logic                     resp_valid_i,
  input  logic                     resp_last_i,
  input  logic [DATA_WIDTH-1:0]    resp_data_i,
  output logic                     resp_ready_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic [ERR_CNT_WIDTH-1:0] err_count_o,
  output logic                     framing_err_o,
  output logic [ADDR_WIDTH-1:0]    first_err_addr_o,
  output logic [DATA_WIDTH-1:0]    first_err_data_o
);

  localparam int BW = $clog2(BURST_LENGTH);

  chk_state_e            state;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [BW-1:0]         beat_cnt;
  logic [15:0]           bursts_left;
  logic                  invert_q;
  logic                  err_seen;

  logic [DATA_WIDTH-1:0] exp_val;
  logic                  hs;
  logic                  mismatch;
  logic                  last_slot;
  logic                  burst_end;
  logic                  framing_now;
  logic                  final_hs;
  logic                  start_ok;

  assign resp_ready_o = (state == RUN) && !stall_i;
  assign hs           = resp_valid_i && resp_ready_o;

  assign exp_val      = DATA_WIDTH'(exp_data(64'(addr_cnt), invert_q));
  assign mismatch     = (resp_data_i != exp_val);

  // A burst closes on whichever comes first: the nominal last slot or an
  // early resp_last_i. Any disagreement between the two is a framing error.
  assign last_slot    = (beat_cnt == BW'(BURST_LENGTH - 1));
  assign burst_end    = last_slot || resp_last_i;
  assign framing_now  = (resp_last_i != last_slot);
  assign final_hs     = hs && burst_end && (bursts_left == 16'd1);

  // start_i is ignored while a run is in progress.
  assign start_ok     = start_i && (state != RUN);

  sat_counter #(
    .WIDTH (ERR_CNT_WIDTH)
  ) u_err_cnt (
    .clk   (clk_axi),
    .rst   (rst_axi),
    .clr   (start_ok),
    .inc   (hs && mismatch),
    .count (err_count_o)
  );

  always_ff @(posedge clk_axi or posedge rst_axi) begin
    if (rst_axi) begin
      state            <= IDLE;
      addr_cnt         <= '0;
      beat_cnt         <= '0;
      bursts_left      <= '0;
      invert_q         <= 1'b0;
      err_seen         <= 1'b0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      pass_o           <= 1'b0;
      framing_err_o    <= 1'b0;
      first_err_addr_o <= '0;
      first_err_data_o <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            addr_cnt         <= base_addr_i;
            invert_q         <= invert_i;
            bursts_left      <= num_bursts_i;
            beat_cnt         <= '0;
            err_seen         <= 1'b0;
            framing_err_o    <= 1'b0;
            first_err_addr_o <= '0;
            first_err_data_o <= '0;
            if (num_bursts_i == 16'd0) begin
              // Nothing to receive: finish immediately with a clean result.
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
              pass_o <= 1'b1;
            end else begin
              state  <= RUN;
              busy_o <= 1'b1;
              done_o <= 1'b0;
              pass_o <= 1'b0;
            end
          end
        end

        RUN: begin
          if (hs) begin
            addr_cnt <= addr_cnt + 1'b1;
            beat_cnt <= burst_end ? '0 : beat_cnt + 1'b1;
            if (framing_now) begin
              framing_err_o <= 1'b1;
            end
            if (mismatch && !err_seen) begin
              err_seen         <= 1'b1;
              first_err_addr_o <= addr_cnt;
              first_err_data_o <= resp_data_i;
            end
            if (burst_end) begin
              bursts_left <= bursts_left - 1'b1;
            end
            if (final_hs) begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
              // Fold in this beat's own result, which is not yet in the flags.
              pass_o <= !(framing_err_o || framing_now || err_seen || mismatch);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_resp_checker.sv
// Directed self-checking bench for sdram_resp_checker.
// Latency: n/a (testbench).
// Backpressure: driver model holds each beat until it is accepted.
module tb_sdram_resp_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] base_addr = '0;
  logic [15:0] num_bursts = '0;
  logic        invert = 1'b0;
  logic        stall = 1'b0;
  logic        resp_valid = 1'b0;
  logic        resp_last = 1'b0;
  logic [15:0] resp_data = '0;

  logic        resp_ready, busy, done, pass, framing_err;
  logic [15:0] err_count;
  logic [23:0] first_err_addr;
  logic [15:0] first_err_data;

  logic        s_resp_ready, s_busy, s_done, s_pass, s_framing_err;
  logic [3:0]  s_err_count;
  logic [23:0] s_first_err_addr;
  logic [15:0] s_first_err_data;

  int n_checks = 0;
  int n_fail   = 0;
  bit stall_mode = 1'b0;

  always #5 clk = ~clk;

  sdram_resp_checker dut (
    .clk_axi          (clk),
    .rst_axi          (rst),
    .start_i          (start),
    .base_addr_i      (base_addr),
    .num_bursts_i     (num_bursts),
    .invert_i         (invert),
    .stall_i          (stall),
    .resp_valid_i     (resp_valid),
    .resp_last_i      (resp_last),
    .resp_data_i      (resp_data),
    .resp_ready_o     (resp_ready),
    .busy_o           (busy),
    .done_o           (done),
    .pass_o           (pass),
    .err_count_o      (err_count),
    .framing_err_o    (framing_err),
    .first_err_addr_o (first_err_addr),
    .first_err_data_o (first_err_data)
  );

  // Narrow error counter to exercise saturation on the same stimulus.
  sdram_resp_checker #(.ERR_CNT_WIDTH(4)) dut_sat (
    .clk_axi          (clk),
    .rst_axi          (rst),
    .start_i          (start),
    .base_addr_i      (base_addr),
    .num_bursts_i     (num_bursts),
    .invert_i         (invert),
    .stall_i          (stall),
    .resp_valid_i     (resp_valid),
    .resp_last_i      (resp_last),
    .resp_data_i      (resp_data),
    .resp_ready_o     (s_resp_ready),
    .busy_o           (s_busy),
    .done_o           (s_done),
    .pass_o           (s_pass),
    .err_count_o      (s_err_count),
    .framing_err_o    (s_framing_err),
    .first_err_addr_o (s_first_err_addr),
    .first_err_data_o (s_first_err_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send_beat(input logic [15:0] d, input logic l, output int cyc);
    logic ok;
    int   guard;
    ok = 1'b0;
    guard = 0;
    cyc = 0;
    resp_valid = 1'b1;
    resp_data  = d;
    resp_last  = l;
    while (!ok && guard < 200) begin
      @(negedge clk);
      ok = resp_ready;
      @(posedge clk);
      #1;
      if (stall_mode) stall = ~stall;
      cyc++;
      guard++;
    end
    if (!ok) chk("hs_timeout", 32'(ok), 32'd1);
  endtask

  // Streams n beats from base; first burst has first_len beats, the rest 8.
  // Beats with index in [bad_lo, bad_hi] return bad_d instead of the pattern.
  task automatic stream(input logic [23:0] base, input logic inv, input int n,
                        input int first_len, input int bad_lo, input int bad_hi,
                        input logic [15:0] bad_d, output int cycles);
    logic [23:0] a;
    logic [15:0] d;
    logic        l;
    int          p;
    int          len;
    int          c1;
    p = 0;
    len = first_len;
    cycles = 0;
    for (int i = 0; i < n; i++) begin
      a = base + 24'(i);
      d = inv ? ~a[15:0] : a[15:0];
      if (i >= bad_lo && i <= bad_hi) d = bad_d;
      l = (p == len - 1);
      send_beat(d, l, c1);
      cycles += c1;
      if (l) begin
        p = 0;
        len = 8;
      end else begin
        p++;
      end
    end
    resp_valid = 1'b0;
    resp_last  = 1'b0;
  endtask

  task automatic do_start(input logic [23:0] base, input logic [15:0] nb, input logic inv);
    base_addr  = base;
    num_bursts = nb;
    invert     = inv;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
  endtask

  logic [15:0] bp_tab [8];
  int          cyc;

  initial begin
    bp_tab = '{16'h0003, 16'h0002, 16'h0001, 16'h0000,
               16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC};

    // Reset values
    #12;
    chk("rst_ready",  32'(resp_ready), 32'd0);
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_done",   32'(done), 32'd0);
    chk("rst_pass",   32'(pass), 32'd0);
    chk("rst_errcnt", 32'(err_count), 32'd0);
    chk("rst_frame",  32'(framing_err), 32'd0);
    chk("rst_feaddr", 32'(first_err_addr), 32'd0);
    chk("rst_fedata", 32'(first_err_data), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Clean run: 4 bursts from 0x000100, no bubbles
    do_start(24'h000100, 16'd4, 1'b0);
    chk("clean_busy",  32'(busy), 32'd1);
    chk("clean_ready", 32'(resp_ready), 32'd1);
    chk("clean_done0", 32'(done), 32'd0);
    stream(24'h000100, 1'b0, 32, 8, -1, -1, 16'h0, cyc);
    chk("clean_cycles", 32'(cyc), 32'd32);
    chk("clean_done",   32'(done), 32'd1);
    chk("clean_busy0",  32'(busy), 32'd0);
    chk("clean_ready0", 32'(resp_ready), 32'd0);
    chk("clean_pass",   32'(pass), 32'd1);
    chk("clean_errcnt", 32'(err_count), 32'd0);
    chk("clean_frame",  32'(framing_err), 32'd0);

    // Single corruption at 0x000105
    do_start(24'h000100, 16'd2, 1'b0);
    chk("corr_done0", 32'(done), 32'd0);
    stream(24'h000100, 1'b0, 16, 8, 5, 5, 16'hDEAD, cyc);
    chk("corr_done",   32'(done), 32'd1);
    chk("corr_errcnt", 32'(err_count), 32'd1);
    chk("corr_feaddr", 32'(first_err_addr), 32'h000105);
    chk("corr_fedata", 32'(first_err_data), 32'hDEAD);
    chk("corr_pass",   32'(pass), 32'd0);
    chk("corr_frame",  32'(framing_err), 32'd0);

    // Framing: first burst ends early on beat 5, second burst resyncs
    do_start(24'h000400, 16'd2, 1'b0);
    chk("frm_errcnt_clr", 32'(err_count), 32'd0);
    chk("frm_feaddr_clr", 32'(first_err_addr), 32'd0);
    stream(24'h000400, 1'b0, 14, 6, -1, -1, 16'h0, cyc);
    chk("frm_done",   32'(done), 32'd1);
    chk("frm_frame",  32'(framing_err), 32'd1);
    chk("frm_errcnt", 32'(err_count), 32'd0);
    chk("frm_pass",   32'(pass), 32'd0);

    // Backpressure and address wrap with inverted pattern
    do_start(24'hFFFFFC, 16'd1, 1'b1);
    stall_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_beat(bp_tab[i], (i == 7), cyc);
    end
    resp_valid = 1'b0;
    resp_last  = 1'b0;
    stall_mode = 1'b0;
    stall      = 1'b0;
    chk("bp_done",   32'(done), 32'd1);
    chk("bp_pass",   32'(pass), 32'd1);
    chk("bp_errcnt", 32'(err_count), 32'd0);
    chk("bp_frame",  32'(framing_err), 32'd0);

    // Zero bursts: done and pass on the next cycle
    do_start(24'h000000, 16'd0, 1'b0);
    chk("zero_done",  32'(done), 32'd1);
    chk("zero_pass",  32'(pass), 32'd1);
    chk("zero_busy",  32'(busy), 32'd0);
    chk("zero_ready", 32'(resp_ready), 32'd0);

    // Saturation: 20 corrupt beats out of 24
    do_start(24'h000200, 16'd3, 1'b0);
    stream(24'h000200, 1'b0, 24, 8, 0, 19, 16'hDEAD, cyc);
    chk("sat_done",      32'(done), 32'd1);
    chk("sat_errcnt16",  32'(err_count), 32'd20);
    chk("sat_errcnt4",   32'(s_err_count), 32'hF);
    chk("sat_feaddr",    32'(first_err_addr), 32'h000200);
    chk("sat_fedata",    32'(first_err_data), 32'hDEAD);
    chk("sat_pass",      32'(pass), 32'd0);

    // Reset mid-run (during burst 2) aborts asynchronously
    do_start(24'h000300, 16'd4, 1'b0);
    stream(24'h000300, 1'b0, 10, 8, 2, 2, 16'hDEAD, cyc);
    chk("mid_errcnt", 32'(err_count), 32'd1);
    chk("mid_busy",   32'(busy), 32'd1);
    resp_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ready",  32'(resp_ready), 32'd0);
    chk("arst_busy",   32'(busy), 32'd0);
    chk("arst_done",   32'(done), 32'd0);
    chk("arst_pass",   32'(pass), 32'd0);
    chk("arst_errcnt", 32'(err_count), 32'd0);
    chk("arst_feaddr", 32'(first_err_addr), 32'd0);
    chk("arst_fedata", 32'(first_err_data), 32'd0);
    resp_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_ready_hold", 32'(resp_ready), 32'd0);

    // Fresh run after reset
    do_start(24'h000500, 16'd1, 1'b0);
    stream(24'h000500, 1'b0, 8, 8, -1, -1, 16'h0, cyc);
    chk("fresh_done",   32'(done), 32'd1);
    chk("fresh_pass",   32'(pass), 32'd1);
    chk("fresh_errcnt", 32'(err_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdram_resp_checker.md
# sdram_resp_checker

Consumes the read-response stream (`resp_valid`/`resp_last`/`resp_data`/`resp_ready`) produced by `SdramDriver` and checks every beat against an address-derived expected pattern. It also checks burst framing, counts mismatches and latches the first failing beat. It sits directly downstream of the driver's response port in the SDRAM bring-up design. It lets the tester's FSM issue reads without inspecting data itself, and its outputs feed the LED / seven-segment feedback.

## Interface
Parameters:
- `ADDR_WIDTH`, 24, word address width (matches driver)
- `DATA_WIDTH`, 16, response data width; must be ≤ `ADDR_WIDTH`
- `BURST_LENGTH`, 8, beats per burst; power of two, ≥ 2
- `ERR_CNT_WIDTH`, 16, mismatch counter width (saturating)

Ports:
- `clk_axi`  in  1  single clock for the whole block
- `rst_axi`  in  1  reset, asynchronous, active-high
- `start_i`  in  1  one-cycle pulse; latches config and starts a check run
- `base_addr_i`  in  ADDR_WIDTH  word address of the first expected beat
- `num_bursts_i`  in  16  bursts to receive in this run
- `invert_i`  in  1  0: expected = addr[DATA_WIDTH-1:0]; 1: bitwise inverse
- `stall_i`  in  1  test hook; forces `resp_ready_o` low
- `resp_valid_i`  in  1  driver response valid
- `resp_last_i`  in  1  driver marks final beat of a burst
- `resp_data_i`  in  DATA_WIDTH  response data
- `resp_ready_o`  out  1  beat accepted when valid & ready
- `busy_o`  out  1  run in progress
- `done_o`  out  1  run complete; held until next `start_i`
- `pass_o`  out  1  `done_o` & no mismatch & no framing error
- `err_count_o`  out  ERR_CNT_WIDTH  data mismatches, saturating
- `framing_err_o`  out  1  sticky; `resp_last_i` misplaced
- `first_err_addr_o`  out  ADDR_WIDTH  address of first mismatch
- `first_err_data_o`  out  DATA_WIDTH  data received at first mismatch

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on `start_i` when `num_bursts_i` ≠ 0. IDLE → DONE directly when `num_bursts_i` = 0, with `pass_o` = 1.
- The `start_i` transition latches the base address into the address counter, `invert_i`, and `num_bursts_i`. It clears counters, the sticky flags and the first-error registers.
- RUN → DONE on the handshake that completes burst number `num_bursts_i`.
- DONE → RUN, or DONE → DONE for a zero-burst start, on `start_i`.
- `start_i` while in RUN is ignored.
- `resp_ready_o` = (state == RUN) & ~`stall_i`, combinational from registered state. It is 0 in IDLE and DONE.
- Handshake = `resp_valid_i` & `resp_ready_o`. Each handshake:
  - Compare `resp_data_i` with the expected value.
  - Increment the address counter; it wraps modulo 2^ADDR_WIDTH.
  - Increment the beat counter; it wraps modulo BURST_LENGTH.
- Mismatch: increment `err_count_o`, saturating at all-ones. If this is the first mismatch of the run, latch the address and data.
- Framing:
  - A burst ends on the handshake where beat == BURST_LENGTH-1 or where `resp_last_i` = 1, whichever comes first.
  - If `resp_last_i` disagrees with (beat == BURST_LENGTH-1), set `framing_err_o`.
  - The beat counter resyncs to 0 after every burst end.
- Simultaneous mismatch and framing error on one beat: both are recorded.

## Timing
- Reset values: state IDLE, `resp_ready_o` 0, `busy_o` 0, `done_o` 0, `pass_o` 0, `err_count_o` 0, `framing_err_o` 0, first-error registers 0.
- Reset mid-run aborts immediately. Beats in flight are dropped, with no further ready.
- `busy_o` rises the cycle after `start_i`.
- All status outputs are registered. They update the cycle after the handshake that causes them.
- `done_o`/`pass_o` assert the cycle after the final handshake. In that same cycle `busy_o` falls and `resp_ready_o` = 0.
- Throughput: one beat per cycle; no bubbles while `stall_i` = 0.
- Expected data is pure combinational from the address counter.

## Structure
- Shared package `sdram_test_pkg` holds:
  - `chk_state_e` (IDLE, RUN, DONE)
  - the expected-pattern function `exp_data(addr, invert)`
  - the default burst-length constant, shared with the tester
- One natural sub-module, `sat_counter` (parameterised width, increment, clear, saturate), used for `err_count_o`. All other logic is flat.

## Test plan
- Clean run:
  - Stimulus: base 0x000100, 4 bursts, invert 0, driver model returns addr[15:0], `resp_last_i` on every 8th beat.
  - Required: `done_o` 1 cycle after beat 32, `pass_o` 1, `err_count_o` 0.
- Single corruption:
  - Stimulus: beat at address 0x000105 returns 0xDEAD.
  - Required: `err_count_o` 1, `first_err_addr_o` 0x000105, `first_err_data_o` 0xDEAD, `pass_o` 0.
- Framing:
  - Stimulus: `resp_last_i` on beat 5 of burst 1.
  - Required: `framing_err_o` 1; subsequent bursts counted from a resynced beat 0; `done_o` after the 2nd burst end with `num_bursts_i` = 2.
- Backpressure and wrap:
  - Stimulus: base 0xFFFFFC, invert 1, `stall_i` toggled every other cycle.
  - Required: no beats lost; expected values 0x0003, 0x0002, 0x0001, 0x0000, 0xFFFF…; pass.
- Zero bursts and saturation:
  - Stimulus: `num_bursts_i` 0.
  - Required: DONE and pass the next cycle.
  - Stimulus: `ERR_CNT_WIDTH` = 4, 20 corrupt beats.
  - Required: `err_count_o` = 0xF.
- Reset mid-run:
  - Stimulus: assert `rst_axi` during burst 2.
  - Required: all outputs at reset values asynchronously; a fresh `start_i` then runs clean.
